fetch_ctrl: RTL

//  Instruction-fetch sequencer in front of the instruction ROM: owns the PC, drives ROM ce/addr,

---
 rtl/fetch_ctrl_pkg.sv | 11 +
 rtl/fetch_ctrl_if.sv | 24 ++
 rtl/fetch_ctrl_buf.sv | 55 +++++
 rtl/fetch_ctrl.sv | 123 ++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// fetch_pkg: shared types and sizing for the instruction-fetch sequencer.
//   fetch_state_e   : sequencer FSM states
//   FETCH_BUF_DEPTH : response buffer depth (also the fetch credit limit)
package fetch_pkg;
  typedef enum logic [1:0] {IDLE, RUN, STALL, REDIR} fetch_state_e;

  localparam int FETCH_BUF_DEPTH = 2;
  // Buffer pointers wrap by natural overflow, so the depth must stay a power of two.
  localparam int FETCH_PTR_W = $clog2(FETCH_BUF_DEPTH);
  localparam int FETCH_CNT_W = $clog2(FETCH_BUF_DEPTH + 1);
endpackage

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: ROM read bus plus the instruction valid/ready handshake to decode.
//   master : fetch sequencer side (drives ROM ce/addr and the instruction stream)
//   slave  : environment side (ROM data and decode ready)
interface fetch_ctrl_if #(
  parameter int NPC   = 6,
  parameter int NINST = 32
);
  logic             o_rom_ce;
  logic [NPC-1:0]   o_rom_addr;
  logic [NINST-1:0] i_rom_data;
  logic             o_inst_valid;
  logic             i_inst_ready;
  logic [NINST-1:0] o_inst;
  logic [NPC-1:0]   o_inst_pc;

  modport master (
    output o_rom_ce, o_rom_addr, o_inst_valid, o_inst, o_inst_pc,
    input  i_rom_data, i_inst_ready
  );
  modport slave (
    input  o_rom_ce, o_rom_addr, o_inst_valid, o_inst, o_inst_pc,
    output i_rom_data, i_inst_ready
  );
endinterface

// File: rtl/fetch_ctrl_buf.sv
// fetch_buf: FETCH_BUF_DEPTH-entry FIFO of {pc, inst} between ROM response and decode.
//   push/push_pc/push_inst : write one entry
//   pop                    : drop head entry (ignored when empty)
//   flush                  : empty the FIFO; wins over a same-cycle push
//   head_pc/head_inst      : current head entry
//   count                  : number of valid entries
module fetch_buf
  import fetch_pkg::*;
#(
  parameter int NPC   = 6,
  parameter int NINST = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [NPC-1:0]         push_pc,
  input  logic [NINST-1:0]       push_inst,
  input  logic                   pop,
  input  logic                   flush,
  output logic [NPC-1:0]         head_pc,
  output logic [NINST-1:0]       head_inst,
  output logic [FETCH_CNT_W-1:0] count
);
  logic [FETCH_BUF_DEPTH-1:0][NPC-1:0]   pc_q;
  logic [FETCH_BUF_DEPTH-1:0][NINST-1:0] inst_q;
  logic [FETCH_PTR_W-1:0]                wr_ptr, rd_ptr;
  logic                                  do_push, do_pop;

  assign do_push   = push && !flush;
  assign do_pop    = pop && (count != '0);
  assign head_pc   = pc_q[rd_ptr];
  assign head_inst = inst_q[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= '0;
      inst_q <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        pc_q[wr_ptr]   <= push_pc;
        inst_q[wr_ptr] <= push_inst;
        wr_ptr         <= wr_ptr + FETCH_PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + FETCH_PTR_W'(1);
      count <= count + FETCH_CNT_W'(do_push) - FETCH_CNT_W'(do_pop);
    end
  end
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer in front of the instruction ROM.
// Owns the PC, issues ROM reads, absorbs the 1-cycle ROM latency in a 2-entry
// buffer and presents instructions to decode over valid/ready.
//   i_clk, i_rst_n  : clock, async active-low reset
//   i_stall         : suppress new ROM issues
//   i_br_valid      : 1-cycle redirect strobe, i_br_target = new PC
//   bus (master)    : ROM ce/addr/data and inst valid/ready/inst/pc
// Optional: `FETCH_CTRL_PERF_EN adds o_perf_fetch (popped insts) and
//   o_perf_stall (cycles spent in STALL or REDIR), both 32-bit wrapping.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int NPC   = 6,
  parameter int NINST = 32
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_stall,
  input  logic           i_br_valid,
  input  logic [NPC-1:0] i_br_target,
  fetch_ctrl_if.master   bus
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [31:0]    o_perf_fetch,
  output logic [31:0]    o_perf_stall
`endif
);
  localparam int OW = FETCH_CNT_W + 1;

  fetch_state_e           state, state_nxt;
  logic [NPC-1:0]         pc, inflight_pc, head_pc;
  logic [NINST-1:0]       head_inst;
  logic [FETCH_CNT_W-1:0] count;
  logic [OW-1:0]          occ;
  logic                   inflight, inflight_epoch, epoch;
  logic                   issue, pop, push, redirect, valid;

  assign valid    = (count != '0);
  assign pop      = valid && bus.i_inst_ready;
  assign redirect = i_br_valid && (state != IDLE);
  // Slots already claimed after this cycle's pop; a new issue needs a free one.
  assign occ      = OW'(count) + OW'(inflight) - OW'(pop);
  // A response fetched before the last redirect carries the old epoch and is dropped.
  assign push     = inflight && (inflight_epoch == epoch);

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    unique case (state)
      IDLE:  state_nxt = RUN;
      RUN: begin
        if (redirect)     state_nxt = REDIR;
        else if (i_stall) state_nxt = STALL;
        else              issue = (occ < OW'(FETCH_BUF_DEPTH));
      end
      STALL: begin
        if (redirect)      state_nxt = REDIR;
        else if (!i_stall) state_nxt = RUN;
      end
      REDIR: begin
        if (redirect)     state_nxt = REDIR;
        else if (i_stall) state_nxt = STALL;
        else              state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state          <= IDLE;
      pc             <= '0;
      inflight       <= 1'b0;
      inflight_pc    <= '0;
      inflight_epoch <= 1'b0;
      epoch          <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= issue;
      if (issue) begin
        inflight_pc    <= pc;
        inflight_epoch <= epoch;
      end
      if (redirect) begin
        pc    <= i_br_target;
        epoch <= ~epoch;
      end else if (issue) begin
        pc <= pc + NPC'(1);
      end
    end
  end

  fetch_buf #(.NPC(NPC), .NINST(NINST)) u_buf (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .push      (push),
    .push_pc   (inflight_pc),
    .push_inst (bus.i_rom_data),
    .pop       (pop),
    .flush     (redirect),
    .head_pc   (head_pc),
    .head_inst (head_inst),
    .count     (count)
  );

  assign bus.o_rom_ce     = issue;
  assign bus.o_rom_addr   = pc;
  assign bus.o_inst_valid = valid;
  assign bus.o_inst       = valid ? head_inst : '0;
  assign bus.o_inst_pc    = valid ? head_pc : '0;

`ifdef FETCH_CTRL_PERF_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_perf_fetch <= '0;
      o_perf_stall <= '0;
    end else begin
      if (pop) o_perf_fetch <= o_perf_fetch + 32'd1;
      if (state == STALL || state == REDIR) o_perf_stall <= o_perf_stall + 32'd1;
    end
  end
`endif
endmodule
